regfile_mp: RTL and testbench



---
 rtl/regfile_mp_if.sv | 44 ++++
 rtl/regfile_mp.sv | 97 +++++++++
 tb/tb_regfile_mp.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read, write and allocate ports.
// Master side is the scheduler/writeback, slave side is the file.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 4,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   i_rd_addr;
  logic [NRD*XLEN-1:0] o_rd_data;
  logic [NRD-1:0]      o_rd_busy;
  logic [NWR-1:0]      i_wr_en;
  logic [NWR*AW-1:0]   i_wr_addr;
  logic [NWR*XLEN-1:0] i_wr_data;
  logic [NWR-1:0]      i_alloc_en;
  logic [NWR*AW-1:0]   i_alloc_addr;
  logic                o_ready;

  modport master (
    output i_rd_addr,
    output i_wr_en,
    output i_wr_addr,
    output i_wr_data,
    output i_alloc_en,
    output i_alloc_addr,
    input  o_rd_data,
    input  o_rd_busy,
    input  o_ready
  );

  modport slave (
    input  i_rd_addr,
    input  i_wr_en,
    input  i_wr_addr,
    input  i_wr_data,
    input  i_alloc_en,
    input  i_alloc_addr,
    output o_rd_data,
    output o_rd_busy,
    output o_ready
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and sequenced clear.
// REGFILE_MP_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 4,
  parameter int NWR  = 2
) (
  input logic         i_clk,
  input logic         i_rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  logic [0:0]      st;
  logic [AW-1:0]   cnt;
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] mem [NREG];

  logic            run;
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] d;
  logic            b;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;

  assign run = (st == S_RUN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st   <= S_INIT;
      cnt  <= '0;
      busy <= '0;
    end else if (st == S_INIT) begin
      cnt <= cnt + AW'(1);
      if (cnt == LAST)
        st <= S_RUN;
    end else begin
      // Clears first so a same-cycle allocate overrides them.
      for (int j = 0; j < NWR; j++)
        if (bus.i_wr_en[j] && bus.i_wr_addr[j*AW +: AW] != '0)
          busy[bus.i_wr_addr[j*AW +: AW]] <= 1'b0;
      for (int j = 0; j < NWR; j++)
        if (bus.i_alloc_en[j] && bus.i_alloc_addr[j*AW +: AW] != '0)
          busy[bus.i_alloc_addr[j*AW +: AW]] <= 1'b1;
    end
  end

  // Storage kept free of reset so it can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (st == S_INIT) begin
        mem[cnt] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++)
          if (bus.i_wr_en[j] && bus.i_wr_addr[j*AW +: AW] != '0)
            mem[bus.i_wr_addr[j*AW +: AW]] <= bus.i_wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra = '0;
    d = '0;
    b = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.i_rd_addr[k*AW +: AW];
      d = '0;
      b = 1'b0;
      if (run && ra != '0) begin
        d = mem[ra];
        b = busy[ra];
`ifdef REGFILE_MP_BYPASS_EN
        for (int j = 0; j < NWR; j++)
          if (bus.i_wr_en[j] && bus.i_wr_addr[j*AW +: AW] == ra) begin
            d = bus.i_wr_data[j*XLEN +: XLEN];
            b = 1'b0;
          end
        for (int j = 0; j < NWR; j++)
          if (bus.i_alloc_en[j] && bus.i_alloc_addr[j*AW +: AW] == ra)
            b = 1'b1;
`endif
      end
      rd_data[k*XLEN +: XLEN] = d;
      rd_busy[k] = b;
    end
  end

  assign bus.o_rd_data = rd_data;
  assign bus.o_rd_busy = rd_busy;
  assign bus.o_ready   = run;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp.
// Expected bypass results follow REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_wr_en = '0;
    bus.i_alloc_en = '0;
  endtask

  task automatic set_wr(int p, logic [AW-1:0] a, logic [XLEN-1:0] v);
    bus.i_wr_en[p] = 1'b1;
    bus.i_wr_addr[p*AW +: AW] = a;
    bus.i_wr_data[p*XLEN +: XLEN] = v;
  endtask

  task automatic set_alloc(int p, logic [AW-1:0] a);
    bus.i_alloc_en[p] = 1'b1;
    bus.i_alloc_addr[p*AW +: AW] = a;
  endtask

  task automatic set_rd(int k, logic [AW-1:0] a);
    bus.i_rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] rdd(int k);
    return bus.o_rd_data[k*XLEN +: XLEN];
  endfunction

  function automatic logic rdb(int k);
    return bus.o_rd_busy[k];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int k = 0; k < NRD; k++) set_rd(k, AW'(k + 1));
    tick();
    tick();
    n_chk++;
    if (bus.o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready got=%b exp=0", bus.o_ready);
    end
    n_chk++;
    if (bus.o_rd_data !== '0) begin
      n_fail++;
      $display("FAIL rst_data got=%h exp=0", bus.o_rd_data);
    end
    rst = 1'b0;
    for (int i = 0; i < NREG - 1; i++) begin
      set_wr(0, 5'd5, 32'hFFFF_FFFF);
      set_alloc(1, 5'd9);
      tick();
      n_chk++;
      if (bus.o_ready !== 1'b0 || bus.o_rd_busy !== '0 || bus.o_rd_data !== '0) begin
        n_fail++;
        $display("FAIL init_%0d ready=%b busy=%b data=%h exp 0/0/0",
                 i, bus.o_ready, bus.o_rd_busy, bus.o_rd_data);
      end
    end
    idle();
    tick();
    n_chk++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done_ready got=%b exp=1", bus.o_ready);
    end
    for (int a = 0; a < NREG; a++) begin
      set_rd(0, AW'(a));
      #1;
      n_chk++;
      if (rdd(0) !== '0 || rdb(0) !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_x%0d data=%h busy=%b exp 0/0", a, rdd(0), rdb(0));
      end
    end
  endtask

  task automatic test_write();
    idle();
    set_wr(0, 5'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    set_rd(0, 5'd5);
    #1;
    n_chk++;
    if (rdd(0) !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_x5 got=%h exp=deadbeef", rdd(0));
    end
    set_wr(1, 5'd0, 32'h1234);
    tick();
    idle();
    set_rd(1, 5'd0);
    #1;
    n_chk++;
    if (rdd(1) !== '0) begin
      n_fail++;
      $display("FAIL wr_x0 got=%h exp=0", rdd(1));
    end
  endtask

  task automatic test_same_addr();
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    tick();
    idle();
    set_rd(2, 5'd7);
    #1;
    n_chk++;
    if (rdd(2) !== 32'h22) begin
      n_fail++;
      $display("FAIL same_addr got=%h exp=22", rdd(2));
    end
  endtask

  task automatic test_busy();
    set_alloc(0, 5'd9);
    set_alloc(1, 5'd0);
    tick();
    idle();
    set_rd(3, 5'd9);
    set_rd(0, 5'd0);
    set_rd(1, 5'd10);
    #1;
    n_chk++;
    if (rdb(3) !== 1'b1) begin
      n_fail++;
      $display("FAIL alloc_x9 got=%b exp=1", rdb(3));
    end
    n_chk++;
    if (rdb(0) !== 1'b0 || rdb(1) !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_other x0=%b x10=%b exp 0/0", rdb(0), rdb(1));
    end
    set_wr(1, 5'd9, 32'h5);
    tick();
    idle();
    #1;
    n_chk++;
    if (rdb(3) !== 1'b0 || rdd(3) !== 32'h5) begin
      n_fail++;
      $display("FAIL wb_x9 busy=%b data=%h exp 0/5", rdb(3), rdd(3));
    end
    set_alloc(1, 5'd9);
    set_wr(0, 5'd9, 32'h6);
    tick();
    idle();
    #1;
    n_chk++;
    if (rdb(3) !== 1'b1 || rdd(3) !== 32'h6) begin
      n_fail++;
      $display("FAIL alloc_wr_x9 busy=%b data=%h exp 1/6", rdb(3), rdd(3));
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp_d;
    logic exp_b;
    set_wr(0, 5'd3, 32'h1);
    tick();
    idle();
    set_alloc(0, 5'd3);
    tick();
    idle();
    set_rd(1, 5'd3);
    set_wr(0, 5'd3, 32'h0000_0BAD);
    set_wr(1, 5'd3, 32'hA5A5_A5A5);
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    exp_d = 32'hA5A5_A5A5;
    exp_b = 1'b0;
`else
    exp_d = 32'h1;
    exp_b = 1'b1;
`endif
    n_chk++;
    if (rdd(1) !== exp_d || rdb(1) !== exp_b) begin
      n_fail++;
      $display("FAIL bypass_rd data=%h busy=%b exp %h/%b", rdd(1), rdb(1), exp_d, exp_b);
    end
    set_alloc(1, 5'd3);
    #1;
    n_chk++;
    if (rdb(1) !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_alloc busy=%b exp=1", rdb(1));
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (rdd(1) !== 32'hA5A5_A5A5 || rdb(1) !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_after data=%h busy=%b exp a5a5a5a5/1", rdd(1), rdb(1));
    end
  endtask

  task automatic test_mid_reset();
    idle();
    set_rd(0, 5'd5);
    set_rd(3, 5'd9);
    #1;
    n_chk++;
    if (rdd(0) !== 32'hDEAD_BEEF || rdb(3) !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst x5=%h busy9=%b exp deadbeef/1", rdd(0), rdb(3));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (bus.o_ready !== 1'b0 || rdb(3) !== 1'b0 || rdd(0) !== '0) begin
      n_fail++;
      $display("FAIL mid_rst ready=%b busy9=%b x5=%h exp 0/0/0", bus.o_ready, rdb(3), rdd(0));
    end
    for (int i = 0; i < NREG - 1; i++) begin
      set_wr(1, 5'd5, 32'hCAFE_0000 + 32'(i));
      set_alloc(0, 5'd9);
      tick();
      n_chk++;
      if (bus.o_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_init_%0d ready=%b exp=0", i, bus.o_ready);
      end
    end
    idle();
    tick();
    n_chk++;
    if (bus.o_ready !== 1'b1 || rdd(0) !== '0 || rdb(3) !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst ready=%b x5=%h busy9=%b exp 1/0/0", bus.o_ready, rdd(0), rdb(3));
    end
  endtask

  initial begin
    bus.i_rd_addr = '0;
    bus.i_wr_en = '0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
    bus.i_alloc_en = '0;
    bus.i_alloc_addr = '0;
    test_reset();
    test_write();
    test_same_addr();
    test_busy();
    test_bypass();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
